// File: rtl/avalon_stall_pkg.sv
// Shared types and default configuration for the Avalon waitrequest stall controller.
package avalon_stall_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } stall_state_t;

    localparam int DEF_N_CH           = 2;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_HOLD_CYCLES    = 1;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/avalon_stall_chan.sv
// One Avalon bus channel: wait/hold FSM, hold counter and readdata capture register.
// Optional hung-bus timeout is enabled with the STALL_TIMEOUT_EN macro.
module avalon_stall_chan
    import avalon_stall_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    input  logic              timeout_clr,
    output logic              ch_stall,
    output logic [DATA_W-1:0] rdata_q,
    output logic              rdata_valid,
    output logic              timeout_err
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    stall_state_t      state, next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              capture;
    logic              clear_valid;
    logic              start_hold;
    logic              timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A waited transfer finishes on the first requested cycle with waitrequest low.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        clear_valid = 1'b0;
        start_hold  = 1'b0;
        case (state)
            IDLE: begin
                if (req && waitrequest) begin
                    next_state  = WAIT;
                    clear_valid = 1'b1;
                end else if (req) begin
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (!waitrequest) begin
                    capture    = 1'b1;
                    start_hold = (HOLD_CYCLES > 0);
                    next_state = (HOLD_CYCLES > 0) ? HOLD : IDLE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ch_stall = (req & waitrequest & ~timeout_err) | (state == HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt    <= '0;
            rdata_q     <= '0;
            rdata_valid <= 1'b0;
        end else begin
            if (start_hold) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (capture) begin
                rdata_q     <= readdata;
                rdata_valid <= 1'b1;
            end else if (clear_valid) begin
                rdata_valid <= 1'b0;
            end
        end
    end

`ifdef STALL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already completed in this transfer.
    assign timeout_hit = (state == WAIT) && req && waitrequest &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT && req && waitrequest) ? wait_cnt + WAIT_W'(1) : '0;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (timeout_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_timeout_clr;

    assign unused_timeout_clr = timeout_clr;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: rtl/avalon_stall_ctrl.sv
// Multi-channel Avalon waitrequest stall controller driving the CPU stall inputs.
// Optional per-channel hung-bus timeout is enabled with the STALL_TIMEOUT_EN macro.
module avalon_stall_ctrl
    import avalon_stall_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        ch_req,
    input  logic [N_CH-1:0]        waitrequest,
    input  logic [N_CH*DATA_W-1:0] readdata,
    input  logic                   timeout_clr,
    output logic [N_CH-1:0]        ch_stall,
    output logic                   stall,
    output logic [N_CH*DATA_W-1:0] rdata_q,
    output logic [N_CH-1:0]        rdata_valid,
    output logic [N_CH-1:0]        timeout_err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        avalon_stall_chan #(
            .DATA_W         (DATA_W),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .req         (ch_req[i]),
            .waitrequest (waitrequest[i]),
            .readdata    (readdata[i*DATA_W +: DATA_W]),
            .timeout_clr (timeout_clr),
            .ch_stall    (ch_stall[i]),
            .rdata_q     (rdata_q[i*DATA_W +: DATA_W]),
            .rdata_valid (rdata_valid[i]),
            .timeout_err (timeout_err[i])
        );
    end

    assign stall = |ch_stall;

endmodule

// File: tb/tb_avalon_stall_ctrl.sv
// Scoreboard bench for avalon_stall_ctrl: three instances (HOLD_CYCLES 0, 1, 3) share one stimulus stream.
// Build with STALL_TIMEOUT_EN defined to exercise the timeout path.
module tb_avalon_stall_ctrl;

    localparam int N_CH = 2;
    localparam int DW   = 32;
    localparam int TO   = 8;
    localparam int NI   = 3;

`ifdef STALL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NI-1:0][N_CH-1:0]    stall;
        logic [NI-1:0]              gstall;
        logic [NI-1:0][N_CH*DW-1:0] rdata;
        logic [NI-1:0][N_CH-1:0]    rvalid;
        logic [NI-1:0][N_CH-1:0]    terr;
    } exp_t;

    exp_t sb_queue[$];
    int   total = 0;
    int   bad   = 0;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [N_CH-1:0]            ch_req = '0;
    logic [N_CH-1:0]            waitrequest = '0;
    logic [N_CH*DW-1:0]         readdata = '0;
    logic                       timeout_clr = 1'b0;
    logic [NI-1:0][N_CH-1:0]    dut_stall;
    logic [NI-1:0]              dut_gstall;
    logic [NI-1:0][N_CH*DW-1:0] dut_rdata;
    logic [NI-1:0][N_CH-1:0]    dut_rvalid;
    logic [NI-1:0][N_CH-1:0]    dut_terr;

    always #5 clk = ~clk;

    avalon_stall_ctrl #(.N_CH(N_CH), .DATA_W(DW), .HOLD_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_h0 (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .waitrequest(waitrequest),
        .readdata(readdata), .timeout_clr(timeout_clr), .ch_stall(dut_stall[0]),
        .stall(dut_gstall[0]), .rdata_q(dut_rdata[0]), .rdata_valid(dut_rvalid[0]),
        .timeout_err(dut_terr[0]));

    avalon_stall_ctrl #(.N_CH(N_CH), .DATA_W(DW), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(TO)) dut_h1 (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .waitrequest(waitrequest),
        .readdata(readdata), .timeout_clr(timeout_clr), .ch_stall(dut_stall[1]),
        .stall(dut_gstall[1]), .rdata_q(dut_rdata[1]), .rdata_valid(dut_rvalid[1]),
        .timeout_err(dut_terr[1]));

    avalon_stall_ctrl #(.N_CH(N_CH), .DATA_W(DW), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(TO)) dut_h3 (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .waitrequest(waitrequest),
        .readdata(readdata), .timeout_clr(timeout_clr), .ch_stall(dut_stall[2]),
        .stall(dut_gstall[2]), .rdata_q(dut_rdata[2]), .rdata_valid(dut_rvalid[2]),
        .timeout_err(dut_terr[2]));

    // Reference model: a channel is either idle, inside a waited transfer, or owes hold_left stall cycles.
    int          m_hold  [NI][N_CH];
    bit          m_busy  [NI][N_CH];
    int          m_wcnt  [NI][N_CH];
    logic [DW-1:0] m_rdata [NI][N_CH];
    bit          m_rv    [NI][N_CH];
    bit          m_terr  [NI][N_CH];

    logic [N_CH-1:0]    p_req = '0;
    logic [N_CH-1:0]    p_wr = '0;
    logic [N_CH*DW-1:0] p_data = '0;
    logic               p_clr = 1'b0;

    function automatic int hold_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                m_hold[k][c]  = 0;
                m_busy[k][c]  = 1'b0;
                m_wcnt[k][c]  = 0;
                m_rdata[k][c] = '0;
                m_rv[k][c]    = 1'b0;
                m_terr[k][c]  = 1'b0;
            end
        end
    endtask

    task automatic modelEdge();
        bit set;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                set = 1'b0;
                if (m_hold[k][c] > 0) begin
                    m_hold[k][c]--;
                end else if (!m_busy[k][c]) begin
                    if (p_req[c] && p_wr[c]) begin
                        m_busy[k][c] = 1'b1;
                        m_rv[k][c]   = 1'b0;
                        m_wcnt[k][c] = 0;
                    end else if (p_req[c]) begin
                        m_rdata[k][c] = p_data[c*DW +: DW];
                        m_rv[k][c]    = 1'b1;
                    end
                end else if (!p_req[c]) begin
                    m_busy[k][c] = 1'b0;
                end else if (!p_wr[c]) begin
                    m_rdata[k][c] = p_data[c*DW +: DW];
                    m_rv[k][c]    = 1'b1;
                    m_busy[k][c]  = 1'b0;
                    m_hold[k][c]  = hold_of(k);
                end else begin
                    m_wcnt[k][c]++;
                    if (TO_EN && m_wcnt[k][c] == TO) begin
                        set          = 1'b1;
                        m_busy[k][c] = 1'b0;
                    end
                end
                if (set) m_terr[k][c] = 1'b1;
                else if (TO_EN && p_clr) m_terr[k][c] = 1'b0;
            end
        end
    endtask

    function automatic exp_t expected();
        exp_t e;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                e.stall[k][c] = (ch_req[c] & waitrequest[c] & ~m_terr[k][c]) | (m_hold[k][c] > 0);
                e.rdata[k][c*DW +: DW] = m_rdata[k][c];
                e.rvalid[k][c] = m_rv[k][c];
                e.terr[k][c]   = m_terr[k][c];
            end
            e.gstall[k] = |e.stall[k];
        end
        return e;
    endfunction

    // One clock cycle: advance the model past the edge, drive new inputs, queue what the DUT must show.
    task automatic applyStimulus(input logic [N_CH-1:0] req, input logic [N_CH-1:0] wr,
                                 input logic [N_CH*DW-1:0] data, input logic clr, input logic rst);
        @(posedge clk);
        #1;
        if (reset_n) modelEdge();
        ch_req      = req;
        waitrequest = wr;
        readdata    = data;
        timeout_clr = clr;
        reset_n     = !rst;
        if (rst) modelReset();
        p_req  = req;
        p_wr   = wr;
        p_data = data;
        p_clr  = clr;
        sb_queue.push_back(expected());
    endtask

    task automatic cmp(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s hold=%0d t=%0t: got %h expected %h", name, hold_of(k), $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        for (int k = 0; k < NI; k++) begin
            cmp("ch_stall", k, 64'(dut_stall[k]), 64'(e.stall[k]));
            cmp("stall", k, 64'(dut_gstall[k]), 64'(e.gstall[k]));
            cmp("rdata_q", k, dut_rdata[k], e.rdata[k]);
            cmp("rdata_valid", k, 64'(dut_rvalid[k]), 64'(e.rvalid[k]));
            cmp("timeout_err", k, 64'(dut_terr[k]), 64'(e.terr[k]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_queue.size() > 0) checkOutput(sb_queue.pop_front());
        end
    end

    initial begin
        logic [N_CH-1:0] rq, wr;
        modelReset();
        $display("[TB] start, timeout feature %0d", TO_EN);
        repeat (2) applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b1);
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        // ch0 waited read: three waited cycles, completes with 0x12345678
        repeat (3) applyStimulus(2'b01, 2'b01, {32'h0, 32'hAAAA0000}, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, {32'h0, 32'h12345678}, 1'b0, 1'b0);
        repeat (5) applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        // zero-wait read
        applyStimulus(2'b01, 2'b00, {32'h0, 32'hDEADBEEF}, 1'b0, 1'b0);
        repeat (3) applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        // overlapping waits: ch0 waits 2, ch1 waits 4, request held through hold
        applyStimulus(2'b11, 2'b11, {32'h11110000, 32'h22220000}, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b11, {32'h11110001, 32'h22220001}, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b10, {32'h11110002, 32'hC0C0C0C0}, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b10, {32'h11110003, 32'h22220003}, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b00, {32'hB1B1B1B1, 32'h22220004}, 1'b0, 1'b0);
        repeat (5) applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        // abort from WAIT, then reset mid-WAIT
        applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b01, '0, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b1);
        applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, {32'h0, 32'h5A5A5A5A}, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b1);
        repeat (3) applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b0);
        repeat (2) applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        // waitrequest stuck high well beyond the timeout limit, then a clear pulse
        repeat (12) applyStimulus(2'b01, 2'b01, '0, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, '0, 1'b1, 1'b0);
        repeat (3) applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        rq = '0;
        wr = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                rq[c] = ($urandom_range(7) != 0);
                wr[c] = wr[c] ? ($urandom_range(9) != 0) : ($urandom_range(2) == 0);
            end
            applyStimulus(rq, wr, {$urandom, $urandom}, ($urandom_range(63) == 0),
                          ($urandom_range(299) == 0));
        end
        applyStimulus(2'b00, 2'b00, '0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        total++;
        if (sb_queue.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_queue.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
